// File: rtl/i2s_phy_out.sv
// rtl/i2s_phy_out.sv - I2S/TDM serial transmitter for one DAC lane
module i2s_phy_out #(
    parameter int  FIFO_DEPTH  = 16,
    parameter int  SYNC_STAGES = 2,
    localparam int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bclk,
    input  logic          lrck,
    output logic          datao,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [31:0]   s_axis_tdata,
    input  logic          s_axis_tlast,
    input  logic          i_enable,
    input  logic [4:0]    i_tdm_num,
    input  logic [5:0]    i_word_width,
    input  logic          i_lrck_polarity,
    input  logic          i_lrck_alignment,
    output logic [31:0]   o_frame_num,
    output logic [15:0]   o_underrun_cnt,
    output logic          o_align_err,
    output logic [AW:0]   o_fifo_level
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DELAY, S_SHIFT, S_GAP} state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q;
    logic                   bclk_prev_q, lrck_last_q, lrck_valid_q;
    logic                   bclk_s, lrck_s, fall, frame_start;

    assign bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];
    assign fall        = bclk_prev_q & ~bclk_s;
    // A start is an lrck change between two falls towards the level selected by the polarity
    assign frame_start = fall & lrck_valid_q & (lrck_last_q != lrck_s) & (lrck_s == ~i_lrck_polarity);

    // Synchronise bclk/lrck and remember lrck as seen at the previous bclk fall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            bclk_prev_q  <= 1'b0;
            lrck_last_q  <= 1'b0;
            lrck_valid_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
            bclk_prev_q <= bclk_s;
            if (fall) begin
                lrck_last_q  <= lrck_s;
                lrck_valid_q <= 1'b1;
            end
        end
    end

    logic [32:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, level;
    logic        full, empty, push, pop;
    logic [32:0] rd_word;

    assign level         = wr_ptr_q - rd_ptr_q;
    assign full          = (level == FULL_LEVEL);
    assign empty         = (level == '0);
    assign s_axis_tready = rst_n & i_enable & ~full;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];
    assign o_fifo_level  = level;

    // Slot-word storage; validity is defined by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // FIFO pointers; a disabled lane drops everything it holds
    always_ff @(posedge clk) begin
        if (!rst_n || !i_enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    state_t      state_q, state_d;
    logic        datao_q, datao_d, err_q, err_d, step;
    logic [31:0] shift_q, shift_d, frame_q, frame_d, load_word;
    logic [4:0]  bit_q, bit_d, slot_q, slot_d, tdm_q, tdm_d, tdm_in, cur_tdm, cur_bit, cur_slot;
    logic [5:0]  ww_q, ww_d, ww_in, cur_ww;
    logic [15:0] under_q, under_d;

    assign tdm_in = (i_tdm_num == 5'd0) ? 5'd1 : ((i_tdm_num > 5'd16) ? 5'd16 : i_tdm_num);
    assign ww_in  = (i_word_width == 6'd0 || i_word_width > 6'd32) ? 6'd32 : i_word_width;

    // Frame sequencing: frame-start handling, per-fall bit shifting, slot loads and counters
    always_comb begin
        state_d   = state_q;
        datao_d   = datao_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        slot_d    = slot_q;
        tdm_d     = tdm_q;
        ww_d      = ww_q;
        frame_d   = frame_q;
        under_d   = under_q;
        err_d     = 1'b0;
        pop       = 1'b0;
        step      = 1'b0;
        load_word = '0;
        cur_tdm   = tdm_q;
        cur_ww    = ww_q;
        cur_bit   = bit_q;
        cur_slot  = slot_q;
        if (!i_enable) begin
            state_d = S_IDLE;
            datao_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            state_d = S_WAIT;
            datao_d = 1'b0;
        end else if (frame_start) begin
            tdm_d    = tdm_in;
            ww_d     = ww_in;
            frame_d  = frame_q + 32'd1;
            cur_tdm  = tdm_in;
            cur_ww   = ww_in;
            cur_bit  = 5'(ww_in - 6'd1);
            cur_slot = 5'd0;
            bit_d    = cur_bit;
            slot_d   = 5'd0;
            if (i_lrck_alignment) begin
                state_d = S_DELAY;
                datao_d = 1'b0;
            end else begin
                step = 1'b1;
            end
        end else if (fall) begin
            if (state_q == S_DELAY || state_q == S_SHIFT) begin
                step = 1'b1;
            end else if (state_q == S_GAP) begin
                datao_d = 1'b0;
            end
        end
        if (step) begin
            state_d = S_SHIFT;
            if (cur_bit == 5'(cur_ww - 6'd1)) begin
                if (empty) begin
                    if (under_q != 16'hFFFF) under_d = under_q + 16'd1;
                end else begin
                    pop       = 1'b1;
                    load_word = rd_word[31:0];
                    err_d     = rd_word[32] != (cur_slot == cur_tdm - 5'd1);
                end
                datao_d = load_word[31];
                shift_d = {load_word[30:0], 1'b0};
            end else begin
                datao_d = shift_q[31];
                shift_d = {shift_q[30:0], 1'b0};
            end
            if (cur_bit == 5'd0) begin
                if (cur_slot == cur_tdm - 5'd1) begin
                    state_d = S_GAP;
                end else begin
                    slot_d = cur_slot + 5'd1;
                    bit_d  = 5'(cur_ww - 6'd1);
                end
            end else begin
                bit_d = cur_bit - 5'd1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            datao_q <= 1'b0;
            shift_q <= '0;
            bit_q   <= 5'd31;
            slot_q  <= '0;
            tdm_q   <= 5'd1;
            ww_q    <= 6'd32;
            frame_q <= '0;
            under_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            datao_q <= datao_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            slot_q  <= slot_d;
            tdm_q   <= tdm_d;
            ww_q    <= ww_d;
            frame_q <= frame_d;
            under_q <= under_d;
            err_q   <= err_d;
        end
    end

    assign datao          = datao_q;
    assign o_frame_num    = frame_q;
    assign o_underrun_cnt = under_q;
    assign o_align_err    = err_q;

endmodule

// File: tb/tb_i2s_phy_out.sv
// tb/tb_i2s_phy_out.sv - table-driven and randomized bench for i2s_phy_out
module tb_i2s_phy_out;
    localparam int HALF = 6;

    logic        clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, lrck = 1'b0, datao;
    logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        i_enable = 1'b0, i_lrck_polarity = 1'b0, i_lrck_alignment = 1'b0;
    logic [4:0]  i_tdm_num = 5'd2;
    logic [5:0]  i_word_width = 6'd32;
    logic [31:0] o_frame_num;
    logic [15:0] o_underrun_cnt;
    logic        o_align_err;
    logic [4:0]  o_fifo_level;

    int n_vec = 0, n_bad = 0, err_seen = 0;
    int exp_err = 0, exp_frames = 0, exp_under = 0;
    logic [32:0] mq[$];
    logic        got[$];

    typedef struct {
        logic [4:0]  tdm;
        logic [5:0]  ww;
        logic        pol;
        logic        al;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] base;
        logic [15:0] last_mask;
        int          exp_err;
        int          exp_under;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    i2s_phy_out dut (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrck(lrck), .datao(datao),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .i_enable(i_enable), .i_tdm_num(i_tdm_num), .i_word_width(i_word_width),
        .i_lrck_polarity(i_lrck_polarity), .i_lrck_alignment(i_lrck_alignment),
        .o_frame_num(o_frame_num), .o_underrun_cnt(o_underrun_cnt),
        .o_align_err(o_align_err), .o_fifo_level(o_fifo_level)
    );

    always @(posedge clk) if (o_align_err === 1'b1) err_seen <= err_seen + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got_v, exp_v);
        end
    endtask

    task automatic bit_period(input logic lr);
        bclk = 1'b1;
        repeat (HALF) @(negedge clk);
        got.push_back(datao);
        bclk = 1'b0;
        lrck = lr;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (s_axis_tready !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: tready=%b after %0d clk, required 1", s_axis_tready, n);
        end else begin
            mq.push_back({l, d});
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic restart(input logic [4:0] tdm, input logic [5:0] ww, input logic pol, input logic al);
        @(negedge clk);
        i_enable = 1'b0;
        repeat (2) @(negedge clk);
        mq.delete();
        i_tdm_num        = tdm;
        i_word_width     = ww;
        i_lrck_polarity  = pol;
        i_lrck_alignment = al;
        i_enable         = 1'b1;
        @(negedge clk);
    endtask

    // Idle falls, then nframes lrck frames, then trailing falls; model derives every bit from the slot rules
    task automatic run_stream(input int nframes, input int gap);
        int          tdm, ww, al, fl, bad, p, s, k;
        logic        sl;
        logic [31:0] word;
        logic [32:0] e;
        logic        exp_bits[$];
        tdm  = (i_tdm_num == 5'd0) ? 1 : int'(i_tdm_num);
        ww   = (i_word_width == 6'd0) ? 32 : int'(i_word_width);
        al   = int'(i_lrck_alignment);
        sl   = ~i_lrck_polarity;
        fl   = tdm * ww + al + gap;
        if (fl < 2) fl = 2;
        word = '0;
        got.delete();
        for (int i = 0; i < 3; i++) begin
            exp_bits.push_back(1'b0);
            bit_period(~sl);
        end
        for (int f = 0; f < nframes; f++) begin
            exp_frames++;
            for (int n = 0; n < fl; n++) begin
                p = n - al;
                if (p >= 0 && p < tdm * ww) begin
                    s = p / ww;
                    k = p % ww;
                    if (k == 0) begin
                        if (mq.size() == 0) begin
                            word = '0;
                            if (exp_under < 65535) exp_under++;
                        end else begin
                            e    = mq.pop_front();
                            word = e[31:0];
                            if (e[32] != (s == tdm - 1)) exp_err++;
                        end
                    end
                    exp_bits.push_back(word[31-k]);
                end else begin
                    exp_bits.push_back(1'b0);
                end
                bit_period((n < fl / 2) ? sl : ~sl);
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_bits.push_back(1'b0);
            bit_period(~sl);
        end
        bad = 0;
        for (int i = 0; i + 1 < got.size(); i++) if (got[i+1] !== exp_bits[i]) bad++;
        check("stream_bad_bits", bad, 0);
        check("frame_num", o_frame_num, exp_frames);
        check("underrun_cnt", o_underrun_cnt, exp_under);
        check("align_err_pulses", err_seen, exp_err);
        check("fifo_level", o_fifo_level, mq.size());
    endtask

    initial begin
        int          e0, u0, ones, nw;
        logic [31:0] w;
        tbl[0] = '{5'd2, 6'd32, 1'b1, 1'b1, 2, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0, 16'h0002, 0, 0};
        tbl[1] = '{5'd8, 6'd16, 1'b0, 1'b0, 8, 32'hA5A5_0000, 32'hA5A5_1111, 32'hA5A5_0000, 16'h0080, 0, 0};
        tbl[2] = '{5'd8, 6'd16, 1'b0, 1'b0, 8, 32'hA5A5_0000, 32'hA5A5_1111, 32'hA5A5_0000, 16'h0090, 1, 0};
        tbl[3] = '{5'd2, 6'd8,  1'b1, 1'b1, 1, 32'hC300_0000, 32'h0, 32'h0, 16'h0000, 0, 1};
        tbl[4] = '{5'd0, 6'd0,  1'b0, 1'b1, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 16'h0001, 0, 0};
        tbl[5] = '{5'd3, 6'd1,  1'b0, 1'b0, 3, 32'h8000_0000, 32'h0, 32'h8000_0000, 16'h0000, 1, 0};

        // reset state
        i_enable = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_datao", datao, 0);
        check("rst_tready", s_axis_tready, 0);
        check("rst_frame_num", o_frame_num, 0);
        check("rst_underrun", o_underrun_cnt, 0);
        check("rst_align_err", o_align_err, 0);
        check("rst_level", o_fifo_level, 0);
        rst_n = 1'b1;

        // reset in the middle of a frame; the rest of that frame must stay silent
        restart(5'd2, 6'd8, 1'b0, 1'b0);
        push(32'hFF00_0000, 1'b0);
        push(32'hFFFF_FFFF, 1'b1);
        push(32'h1234_5678, 1'b0);
        for (int i = 0; i < 3; i++) bit_period(1'b0);
        for (int n = 0; n < 6; n++) bit_period(1'b1);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_datao", datao, 0);
        check("midrst_level", o_fifo_level, 0);
        check("midrst_frame_num", o_frame_num, 0);
        check("midrst_tready", s_axis_tready, 0);
        rst_n = 1'b1;
        exp_frames = 0;
        exp_under  = 0;
        mq.delete();
        got.delete();
        for (int n = 6; n < 16; n++) bit_period((n < 8) ? 1'b1 : 1'b0);
        for (int i = 0; i < 3; i++) bit_period(1'b0);
        ones = 0;
        foreach (got[i]) if (got[i] !== 1'b0) ones++;
        check("midrst_quiet_bits", ones, 0);
        check("midrst_no_frame", o_frame_num, 0);

        // table of directed frame shapes
        for (int t = 0; t < 6; t++) begin
            restart(tbl[t].tdm, tbl[t].ww, tbl[t].pol, tbl[t].al);
            for (int i = 0; i < tbl[t].nw; i++) begin
                w = (i == 0) ? tbl[t].w0 : (i == 1) ? tbl[t].w1 : tbl[t].base + 32'(i);
                push(w, tbl[t].last_mask[i]);
            end
            e0 = err_seen;
            u0 = int'(o_underrun_cnt);
            run_stream(1, 2);
            check($sformatf("tbl%0d_err", t), err_seen - e0, tbl[t].exp_err);
            check($sformatf("tbl%0d_under", t), int'(o_underrun_cnt) - u0, tbl[t].exp_under);
        end

        // full FIFO: tready drops at 16, extra valid is refused, slots drain one word each
        restart(5'd2, 6'd8, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) push($urandom, 1'(i % 2));
        check("full_level", o_fifo_level, 16);
        check("full_tready", s_axis_tready, 0);
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        check("full_no_push", o_fifo_level, 16);
        run_stream(1, 0);
        check("drain_tready", s_axis_tready, 1);

        // disable at slot 1 bit 10, then resume at a fresh frame
        restart(5'd2, 6'd16, 1'b0, 1'b0);
        push(32'h1234_0000, 1'b0);
        push(32'h0400_0000, 1'b1);
        push(32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 3; i++) bit_period(1'b0);
        for (int n = 0; n < 22; n++) bit_period((n < 17) ? 1'b1 : 1'b0);
        exp_frames++;
        check("dis_bit_before", datao, 1);
        i_enable = 1'b0;
        @(negedge clk);
        check("dis_datao", datao, 0);
        check("dis_level", o_fifo_level, 0);
        check("dis_tready", s_axis_tready, 0);
        mq.delete();
        i_enable = 1'b1;
        @(negedge clk);
        push(32'hCAFE_0000, 1'b0);
        push(32'h8001_0000, 1'b1);
        run_stream(1, 2);

        // randomized frame shapes against the model
        for (int it = 0; it < 8; it++) begin
            restart(5'($urandom_range(1, 4)), 6'($urandom_range(0, 32)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            nw = $urandom_range(0, 2 * int'(i_tdm_num));
            for (int i = 0; i < nw; i++) push($urandom, 1'($urandom_range(0, 1)));
            run_stream(2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
